// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the pad-input synchroniser / debounce slice.
package sync_pkg;

    localparam int SYNC_STAGES_MIN = 2;

    // Width needed to hold values 0..value-1; never returns less than 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One debounced channel: consecutive-tick filter, level flop, edge history and pulse decode.
module debounce_channel
    import sync_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sync_in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic change
);

    logic level_s;
    logic prev_r;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            logic unused_tick_s;
            assign unused_tick_s = tick;
            assign level_s       = sync_in;
        end else begin : g_filter
            localparam int            CW   = clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] count_r;
            logic          level_r;

            // Any matching tick restarts the count, so glitch time is never accumulated.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_r <= '0;
                    level_r <= RESET_BIT;
                end else if (tick) begin
                    if (sync_in == level_r) begin
                        count_r <= '0;
                    end else if (count_r == LAST) begin
                        level_r <= sync_in;
                        count_r <= '0;
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
            end

            assign level_s = level_r;
        end
    endgenerate

    // Edge history follows the level every clock so pulses are exactly one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= RESET_BIT;
        end else begin
            prev_r <= level_s;
        end
    end

    assign out    = level_s;
    assign rise   = level_s & ~prev_r;
    assign fall   = ~level_s & prev_r;
    assign change = level_s ^ prev_r;

endmodule

// File: rtl/sync_debounce.sv
// Multi-bit pad synchroniser feeding WIDTH independent debounce/edge-detect channels.
module sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               STAGES          = 2,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change
);

    generate
        if (STAGES < SYNC_STAGES_MIN) begin : g_stages_check
            $error("sync_debounce: STAGES must be at least %0d", SYNC_STAGES_MIN);
        end
    endgenerate

    // Whole chain kept together here so it can be constrained as one synchroniser group.
    logic [WIDTH-1:0] sync_r [STAGES];

    // Plain flop-to-flop chain, no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_r[i] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= in_data;
            for (int i = 1; i < STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VAL[g])
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .tick    (tick),
                .sync_in (sync_r[STAGES-1][g]),
                .out     (out_data[g]),
                .rise    (rise[g]),
                .fall    (fall[g]),
                .change  (change[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench: three configurations of sync_debounce driven and checked on the falling edge.
module tb_sync_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_a, in_b, in_c;
    logic       tick_b;
    logic       tick_one = 1'b1;
    logic [7:0] out_a, rise_a, fall_a, chg_a;
    logic [7:0] out_b, rise_b, fall_b, chg_b;
    logic [7:0] out_c, rise_c, fall_c, chg_c;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(8), .STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VAL(8'hA5)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick_one), .in_data(in_a),
        .out_data(out_a), .rise(rise_a), .fall(fall_a), .change(chg_a));

    sync_debounce #(.WIDTH(8), .STAGES(2), .DEBOUNCE_CYCLES(3), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick_b), .in_data(in_b),
        .out_data(out_b), .rise(rise_b), .fall(fall_b), .change(chg_b));

    sync_debounce #(.WIDTH(8), .STAGES(3), .DEBOUNCE_CYCLES(0), .RESET_VAL(8'h00)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(tick_one), .in_data(in_c),
        .out_data(out_c), .rise(rise_c), .fall(fall_c), .change(chg_c));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        in_a   = 8'hA5;
        in_b   = 8'h00;
        in_c   = 8'h00;
        tick_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_a",  out_a,  8'hA5);
        check("rst_rise_a", rise_a, 8'h00);
        check("rst_fall_a", fall_a, 8'h00);
        check("rst_chg_a",  chg_a,  8'h00);
        check("rst_out_b",  out_b,  8'h00);
        check("rst_out_c",  out_c,  8'h00);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rel_out_a", out_a, 8'hA5);
            check("rel_chg_a", chg_a, 8'h00);
        end

        // Latency: STAGES=2, N=4 -> flip after the 6th edge
        in_a = 8'hA7;
        repeat (5) begin
            @(negedge clk);
            check("lat_hold_out", out_a, 8'hA5);
            check("lat_hold_chg", chg_a, 8'h00);
        end
        @(negedge clk);
        check("lat_out",  out_a,  8'hA7);
        check("lat_rise", rise_a, 8'h02);
        check("lat_fall", fall_a, 8'h00);
        check("lat_chg",  chg_a,  8'h02);
        @(negedge clk);
        check("lat_rise_end", rise_a, 8'h00);
        check("lat_chg_end",  chg_a,  8'h00);

        // Glitch of 3 clocks rejected
        in_a = 8'hAF;
        repeat (3) @(negedge clk);
        in_a = 8'hA7;
        repeat (8) begin
            @(negedge clk);
            check("glitch_out", out_a, 8'hA7);
            check("glitch_chg", chg_a, 8'h00);
        end
        // 6 clocks passes
        in_a = 8'hAF;
        repeat (5) begin
            @(negedge clk);
            check("long_hold", out_a, 8'hA7);
        end
        @(negedge clk);
        check("long_out",  out_a,  8'hAF);
        check("long_rise", rise_a, 8'h08);
        @(negedge clk);
        check("long_rise_end", rise_a, 8'h00);

        // Tick gating: N=3, tick every 4th clock
        in_b = 8'h01;
        repeat (3) @(negedge clk);
        for (int j = 1; j <= 3; j++) begin
            repeat (3) begin
                @(negedge clk);
                check("tick_idle_out", out_b, (j == 1) ? 8'h00 : 8'h00);
            end
            tick_b = 1'b1;
            @(negedge clk);
            tick_b = 1'b0;
            if (j < 3) begin
                check("tick_early_out", out_b, 8'h00);
                check("tick_early_chg", chg_b, 8'h00);
            end else begin
                check("tick_flip_out",  out_b,  8'h01);
                check("tick_flip_rise", rise_b, 8'h01);
                check("tick_flip_fall", fall_b, 8'h00);
            end
        end
        @(negedge clk);
        check("tick_rise_end", rise_b, 8'h00);
        check("tick_chg_end",  chg_b,  8'h00);
        check("tick_out_hold", out_b,  8'h01);

        // Bypass with STAGES=3
        in_c = 8'h3C;
        repeat (2) begin
            @(negedge clk);
            check("byp_hold", out_c, 8'h00);
        end
        @(negedge clk);
        check("byp_out",  out_c,  8'h3C);
        check("byp_rise", rise_c, 8'h3C);
        @(negedge clk);
        check("byp_rise_end", rise_c, 8'h00);
        in_c = 8'h14;
        repeat (3) @(negedge clk);
        check("byp_out2", out_c,  8'h14);
        check("byp_fall", fall_c, 8'h28);
        check("byp_chg",  chg_c,  8'h28);
        @(negedge clk);
        check("byp_fall_end", fall_c, 8'h00);

        // Async reset mid-count: bit1 at count 2 of 4, out bit1 = 1
        in_a = 8'hAD;
        repeat (4) @(negedge clk);
        check("pre_rst_out", out_a, 8'hAF);
        #2;
        rst_n = 1'b0;
        in_a  = 8'hA5;
        #1;
        check("mid_rst_out",  out_a,  8'hA5);
        check("mid_rst_fall", fall_a, 8'h00);
        check("mid_rst_chg",  chg_a,  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out", out_a, 8'hA5);
        check("post_rst_chg", chg_a, 8'h00);
        // A stale count would flip early; a cleared one needs the full 6 edges
        in_a = 8'hA7;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_hold", out_a, 8'hA5);
        end
        @(negedge clk);
        check("post_rst_flip", out_a,  8'hA7);
        check("post_rst_rise", rise_a, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
